// File: rtl/fetch_unit_if.sv
// Bundle of the fetch stage's memory bus and control-unit handshake.
// Handshake: inst_valid high means inst/pc are valid and stable; the control
// unit retires the instruction by pulsing done for one cycle while inst_valid
// is high, and inst_valid drops the cycle after done is sampled.
interface fetch_unit_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_en;
  logic [15:0]       mem_rdata;
  logic              stall;
  logic              done;
  logic              jump_en;
  logic [ADDR_W-1:0] jump_addr;
  logic [15:0]       inst;
  logic              inst_valid;
  logic [ADDR_W-1:0] pc;
  logic              halted;
  logic [15:0]       retired;

  // Fetch-unit side.
  modport master (
    output mem_addr, mem_en, inst, inst_valid, pc, halted, retired,
    input  mem_rdata, stall, done, jump_en, jump_addr
  );

  // Environment side (memory + control unit).
  modport slave (
    input  mem_addr, mem_en, inst, inst_valid, pc, halted, retired,
    output mem_rdata, stall, done, jump_en, jump_addr
  );
endinterface

// File: rtl/fetch_unit.sv
// BittyPro instruction fetch stage: holds the PC, reads one instruction from
// a synchronous-read memory, presents it stable until the control unit
// retires it, then advances (sequentially or by jump) or halts.
module fetch_unit #(
  parameter int          ADDR_W    = 8,
  parameter logic [15:0] HALT_INST = 16'hFFFF
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus,
  output logic [1:0]   state_dbg
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic              capture;
  logic              retire;
  logic              read_en;
  logic [ADDR_W-1:0] pc_q;
  logic [15:0]       inst_q;
  logic              inst_valid_q;
  logic              halted_q;
  logic [15:0]       retired_q;

  // State register; reset always returns to FETCH.
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  // Next-state decode plus the combinational memory strobe.
  always_comb begin
    state_nxt = state;
    read_en   = 1'b0;
    capture   = 1'b0;
    retire    = 1'b0;
    case (state)
      S_FETCH: begin
        if (!bus.stall) begin
          read_en   = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // Read already issued; stall no longer matters here.
        capture   = 1'b1;
        state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (bus.done) begin
          retire    = 1'b1;
          state_nxt = (inst_q == HALT_INST) ? S_HALT : S_FETCH;
        end
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
      default: state_nxt = S_FETCH;
    endcase
    // Keep the memory quiet while reset is asserted.
    if (reset) read_en = 1'b0;
  end

  // Datapath registers: PC, instruction latch, flags and retire counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= '0;
      inst_q       <= 16'h0000;
      inst_valid_q <= 1'b0;
      halted_q     <= 1'b0;
      retired_q    <= 16'h0000;
    end else begin
      if (capture) begin
        inst_q       <= bus.mem_rdata;
        inst_valid_q <= 1'b1;
      end
      if (retire) begin
        inst_valid_q <= 1'b0;
        retired_q    <= retired_q + 16'd1;
        if (inst_q == HALT_INST) halted_q <= 1'b1;
        else if (bus.jump_en)    pc_q     <= bus.jump_addr;
        else                     pc_q     <= pc_q + 1'b1;
      end
    end
  end

  assign bus.mem_en     = read_en;
  assign bus.mem_addr   = reset ? '0 : pc_q;
  assign bus.inst       = inst_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.pc         = pc_q;
  assign bus.halted     = halted_q;
  assign bus.retired    = retired_q;
  assign state_dbg      = state;

endmodule
